// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad scanner:
//   - debounce FSM state encoding
//   - row drive patterns, indexed by row number (active low)
//   - 16-entry key map, index = row*4 + col -> hex key code
//   - width helpers for the scan prescaler and the debounce counter
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // ROW_PAT[r] drives only row r low.
  localparam logic [3:0][3:0] ROW_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Physical layout:
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D   (* -> E, # -> F)
  // The packed list starts at index 15.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic int presc_width(input int scan_div);
    return (scan_div < 2) ? 1 : $clog2(scan_div);
  endfunction

  function automatic int deb_cnt_width(input int scans);
    return $clog2(scans + 1);
  endfunction

endpackage

// File: rtl/mod_two_flop_sync.sv
// mod_two_flop_sync
//   4-bit two-flop synchronizer for the asynchronous column returns.
//   Resets to 4'b1111, the idle state of the pulled-up columns.
// Ports
//   clk    in  1  system clock
//   reset  in  1  synchronous active-high reset
//   d_i    in  4  asynchronous input
//   q_o    out 4  synchronized output, two cycles of latency
module mod_two_flop_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mod_keypad_scanner.sv
// mod_keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, captures the
//   first pressed position of every full scan, debounces it over whole
//   scans and reports a hex key code.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no key accepted, waiting for any key in a scan
//   DEBOUNCE | candidate key seen in cnt consecutive scans
//   PRESSED  | key accepted, key_held high
//   RELEASE  | held key missing for cnt consecutive scans
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous active-high reset
//   col_n      in   4  column returns, active low, asynchronous
//   row_n      out  4  row drive, active low, one row low at a time
//   key_code   out  4  code of last accepted key, held after release
//   key_valid  out  1  one-cycle pulse on an accepted press
//   key_held   out  1  high from the accepting cycle until release
module mod_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = presc_width(SCAN_DIV);
  localparam int CW = deb_cnt_width(DEBOUNCE_SCANS);
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

  logic [3:0]    col_s;
  logic [PW-1:0] presc_q;
  logic [1:0]    row_q;
  logic [3:0]    row_n_q;
  logic          found_q;
  logic [3:0]    idx_q;
  kp_state_e     state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;

  logic          tc;
  logic          eos;
  logic          row_hit;
  logic [1:0]    hit_col;
  logic          scan_found;
  logic [3:0]    scan_idx;
  logic          same_key;
  logic          cnt_done;

  mod_two_flop_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (col_n),
    .q_o   (col_s)
  );

  assign tc  = (presc_q == PRESC_TC);
  assign eos = tc && (row_q == 2'd3);

  // Lowest pressed column of the current row; earlier rows in this scan
  // already captured win over anything sampled now.
  always_comb begin
    row_hit = ~&col_s;
    hit_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s[c]) hit_col = 2'(c);
    end
    scan_found = found_q || row_hit;
    scan_idx   = found_q ? idx_q : {row_q, hit_col};
  end

  assign same_key = scan_found && (scan_idx == cand_q);
  // With a single-scan debounce the count completes immediately.
  assign cnt_done = (DEBOUNCE_SCANS == 1) || ((int'(cnt_q) + 1) == DEBOUNCE_SCANS);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      row_q   <= 2'd0;
      row_n_q <= ROW_PAT[0];
      found_q <= 1'b0;
      idx_q   <= 4'd0;
    end else if (tc) begin
      presc_q <= '0;
      row_q   <= row_q + 2'd1;
      row_n_q <= ROW_PAT[row_q + 2'd1];
      if (eos) begin
        found_q <= 1'b0;
      end else if (!found_q && row_hit) begin
        found_q <= 1'b1;
        idx_q   <= {row_q, hit_col};
      end
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (eos) begin
        case (state_q)
          ST_IDLE: begin
            if (scan_found) begin
              cand_q <= scan_idx;
              cnt_q  <= CW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= ST_PRESSED;
                key_code_q  <= KEY_MAP[scan_idx];
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (!scan_found) begin
              state_q <= ST_IDLE;
            end else if (scan_idx != cand_q) begin
              cand_q <= scan_idx;
              cnt_q  <= CW'(1);
            end else if (cnt_done) begin
              state_q     <= ST_PRESSED;
              key_code_q  <= KEY_MAP[cand_q];
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!same_key) begin
              state_q <= ST_RELEASE;
              cnt_q   <= CW'(1);
            end
          end
          ST_RELEASE: begin
            if (same_key) begin
              state_q <= ST_PRESSED;
            end else if (cnt_done) begin
              state_q    <= ST_IDLE;
              key_held_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
